me_mv_select: RTL and testbench

ME_MV_SELECT -- requirements
Module: me_mv_select

---
 rtl/me_pkg.sv | 16 +
 rtl/me_mv_select_if.sv | 30 +++
 rtl/me_min_cmp.sv | 56 +++++
 rtl/me_mv_select.sv | 144 ++++++++++++++
 tb/tb_me_mv_select.sv | 359 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/me_pkg.sv
// Shared defaults, MV type and FSM state encoding for the motion-vector selector.
package me_pkg;

  localparam int unsigned DefSadWidth    = 16;
  localparam int unsigned DefSearchRange = 8;
  localparam int unsigned DefMvWidth     = 5;

  typedef logic signed [DefMvWidth-1:0] mv_t;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

endpackage

// File: rtl/me_mv_select_if.sv
// Candidate SAD stream in, best-match results out; master drives candidates, slave is the selector.
interface me_mv_select_if #(
  parameter int unsigned SAD_WIDTH = me_pkg::DefSadWidth,
  parameter int unsigned MV_WIDTH  = me_pkg::DefMvWidth
);

  logic                             start;
  logic                             sad_valid;
  logic [SAD_WIDTH-1:0]             sad16;
  logic [3:0][SAD_WIDTH-1:0]        sad8;
  logic                             busy;
  logic                             done;
  logic [SAD_WIDTH-1:0]             best_sad16;
  logic signed [MV_WIDTH-1:0]       best_mv16_x;
  logic signed [MV_WIDTH-1:0]       best_mv16_y;
  logic [3:0][SAD_WIDTH-1:0]        best_sad8;
  logic [3:0][MV_WIDTH-1:0]         best_mv8_x;
  logic [3:0][MV_WIDTH-1:0]         best_mv8_y;

  modport master (
    output start, sad_valid, sad16, sad8,
    input  busy, done, best_sad16, best_mv16_x, best_mv16_y, best_sad8, best_mv8_x, best_mv8_y
  );

  modport slave (
    input  start, sad_valid, sad16, sad8,
    output busy, done, best_sad16, best_mv16_x, best_mv16_y, best_sad8, best_mv8_x, best_mv8_y
  );

endinterface

// File: rtl/me_min_cmp.sv
// Running-minimum tracker: keeps the smallest SAD seen and the MV it came with.
module me_min_cmp #(
  parameter int unsigned SAD_WIDTH = 16,
  parameter int unsigned MV_WIDTH  = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear_i,
  input  logic                       valid_i,
  input  logic [SAD_WIDTH-1:0]       sad_i,
  input  logic signed [MV_WIDTH-1:0] mv_x_i,
  input  logic signed [MV_WIDTH-1:0] mv_y_i,
  output logic [SAD_WIDTH-1:0]       min_sad_o,
  output logic signed [MV_WIDTH-1:0] min_mv_x_o,
  output logic signed [MV_WIDTH-1:0] min_mv_y_o
);

  logic [SAD_WIDTH-1:0]       min_sad_q, min_sad_d;
  logic signed [MV_WIDTH-1:0] min_mv_x_q, min_mv_x_d;
  logic signed [MV_WIDTH-1:0] min_mv_y_q, min_mv_y_d;

  // Strict less-than: on a tie the earlier candidate stays.
  always_comb begin
    min_sad_d  = min_sad_q;
    min_mv_x_d = min_mv_x_q;
    min_mv_y_d = min_mv_y_q;
    if (clear_i) begin
      min_sad_d  = '1;
      min_mv_x_d = '0;
      min_mv_y_d = '0;
    end else if (valid_i && (sad_i < min_sad_q)) begin
      min_sad_d  = sad_i;
      min_mv_x_d = mv_x_i;
      min_mv_y_d = mv_y_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      min_sad_q  <= '0;
      min_mv_x_q <= '0;
      min_mv_y_q <= '0;
    end else begin
      min_sad_q  <= min_sad_d;
      min_mv_x_q <= min_mv_x_d;
      min_mv_y_q <= min_mv_y_d;
    end
  end

  // Outputs show the minimum including this cycle's candidate, so the parent can
  // capture the final winner on the same edge the last candidate is accepted.
  assign min_sad_o  = min_sad_d;
  assign min_mv_x_o = min_mv_x_d;
  assign min_mv_y_o = min_mv_y_d;

endmodule

// File: rtl/me_mv_select.sv
// Full-search MV selector: scans a raster of candidates and reports the 16x16 and
// per-8x8 minimum-SAD motion vectors.
module me_mv_select
  import me_pkg::*;
#(
  parameter int unsigned SAD_WIDTH    = DefSadWidth,
  parameter int unsigned SEARCH_RANGE = DefSearchRange,
  parameter int unsigned MV_WIDTH     = DefMvWidth
) (
  input logic           clk,
  input logic           rst,
  me_mv_select_if.slave bus
);

  localparam int unsigned NumCmp = 5;
  localparam logic signed [MV_WIDTH-1:0] MvMin = MV_WIDTH'(-int'(SEARCH_RANGE));
  localparam logic signed [MV_WIDTH-1:0] MvMax = MV_WIDTH'(int'(SEARCH_RANGE) - 1);

  state_e state_q, state_d;

  logic                       accept;
  logic                       clear;
  logic                       last_cand;
  logic                       enter_done;
  logic signed [MV_WIDTH-1:0] cur_x_q, cur_x_d;
  logic signed [MV_WIDTH-1:0] cur_y_q, cur_y_d;

  logic [SAD_WIDTH-1:0]       cand_sad [NumCmp];
  logic [SAD_WIDTH-1:0]       cmp_sad  [NumCmp];
  logic signed [MV_WIDTH-1:0] cmp_mx   [NumCmp];
  logic signed [MV_WIDTH-1:0] cmp_my   [NumCmp];
  logic [SAD_WIDTH-1:0]       res_sad_q [NumCmp];
  logic signed [MV_WIDTH-1:0] res_mx_q  [NumCmp];
  logic signed [MV_WIDTH-1:0] res_my_q  [NumCmp];

  assign accept     = (state_q == StRun) && bus.sad_valid;
  assign clear      = (state_q == StIdle) && bus.start;
  assign last_cand  = (cur_x_q == MvMax) && (cur_y_q == MvMax);
  assign enter_done = accept && last_cand;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.start) state_d = StRun;
      StRun:   if (enter_done) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.busy = (state_q != StIdle);
    bus.done = (state_q == StDone);
  end

  // Raster counters: x inner, y outer.
  always_comb begin
    cur_x_d = cur_x_q;
    cur_y_d = cur_y_q;
    if (clear) begin
      cur_x_d = MvMin;
      cur_y_d = MvMin;
    end else if (accept) begin
      if (cur_x_q == MvMax) begin
        cur_x_d = MvMin;
        cur_y_d = cur_y_q + MV_WIDTH'(1);
      end else begin
        cur_x_d = cur_x_q + MV_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cur_x_q <= MvMin;
      cur_y_q <= MvMin;
    end else begin
      cur_x_q <= cur_x_d;
      cur_y_q <= cur_y_d;
    end
  end

  // Slot 0 tracks the 16x16 SAD, slots 1..4 the 8x8 sub-blocks in raster order.
  always_comb begin
    cand_sad[0] = bus.sad16;
    for (int k = 0; k < 4; k++) begin
      cand_sad[k+1] = bus.sad8[k];
    end
  end

  for (genvar g = 0; g < NumCmp; g++) begin : g_cmp
    me_min_cmp #(
      .SAD_WIDTH (SAD_WIDTH),
      .MV_WIDTH  (MV_WIDTH)
    ) u_cmp (
      .clk        (clk),
      .rst        (rst),
      .clear_i    (clear),
      .valid_i    (accept),
      .sad_i      (cand_sad[g]),
      .mv_x_i     (cur_x_q),
      .mv_y_i     (cur_y_q),
      .min_sad_o  (cmp_sad[g]),
      .min_mv_x_o (cmp_mx[g]),
      .min_mv_y_o (cmp_my[g])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < NumCmp; k++) begin
        res_sad_q[k] <= '0;
        res_mx_q[k]  <= '0;
        res_my_q[k]  <= '0;
      end
    end else if (enter_done) begin
      for (int k = 0; k < NumCmp; k++) begin
        res_sad_q[k] <= cmp_sad[k];
        res_mx_q[k]  <= cmp_mx[k];
        res_my_q[k]  <= cmp_my[k];
      end
    end
  end

  always_comb begin
    bus.best_sad16  = res_sad_q[0];
    bus.best_mv16_x = res_mx_q[0];
    bus.best_mv16_y = res_my_q[0];
    for (int k = 0; k < 4; k++) begin
      bus.best_sad8[k]  = res_sad_q[k+1];
      bus.best_mv8_x[k] = res_mx_q[k+1];
      bus.best_mv8_y[k] = res_my_q[k+1];
    end
  end

endmodule

// File: tb/tb_me_mv_select.sv
// Bench for me_mv_select: per-scenario tasks with a queue of expected search results.
module tb_me_mv_select;
  import me_pkg::*;

  typedef struct packed {
    logic [15:0]      sad16;
    logic [4:0]       mx;
    logic [4:0]       my;
    logic [3:0][15:0] sad8;
    logic [3:0][4:0]  m8x;
    logic [3:0][4:0]  m8y;
  } res_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   done_cnt;
  res_t exp_q [$];

  logic [15:0] c16 [256];
  logic [15:0] c8  [4][256];

  me_mv_select_if bus ();

  me_mv_select u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.done === 1'b1) done_cnt <= done_cnt + 1;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic res_t dut_res();
    res_t r;
    r.sad16 = bus.best_sad16;
    r.mx    = bus.best_mv16_x;
    r.my    = bus.best_mv16_y;
    r.sad8  = bus.best_sad8;
    r.m8x   = bus.best_mv8_x;
    r.m8y   = bus.best_mv8_y;
    return r;
  endfunction

  // Reference: scan candidates in raster order from an all-ones minimum, strict less-than.
  function automatic res_t model();
    res_t r;
    r = '0;
    r.sad16 = '1;
    r.sad8  = '1;
    for (int i = 0; i < 256; i++) begin
      mv_t x, y;
      x = mv_t'((i % 16) - 8);
      y = mv_t'((i / 16) - 8);
      if (c16[i] < r.sad16) begin
        r.sad16 = c16[i]; r.mx = x; r.my = y;
      end
      for (int k = 0; k < 4; k++) begin
        if (c8[k][i] < r.sad8[k]) begin
          r.sad8[k] = c8[k][i]; r.m8x[k] = x; r.m8y[k] = y;
        end
      end
    end
    return r;
  endfunction

  // Drives n candidates; done_seen samples done one cycle after the last accept.
  task automatic drive_search(input bit gaps, input bit poke_start, input int n,
                              output bit done_seen, output int early);
    early = 0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        int g;
        g = $urandom_range(0, 2);
        repeat (g) begin
          bus.sad_valid = 1'b0;
          bus.sad16     = 16'($urandom);
          bus.start     = poke_start && ($urandom_range(0, 2) == 0);
          @(negedge clk);
          if (bus.done === 1'b1) early++;
        end
      end
      bus.start     = poke_start && ($urandom_range(0, 3) == 0);
      bus.sad_valid = 1'b1;
      bus.sad16     = c16[i];
      for (int k = 0; k < 4; k++) bus.sad8[k] = c8[k][i];
      @(negedge clk);
      if (bus.done === 1'b1 && i != 255) early++;
    end
    done_seen = (bus.done === 1'b1);
    bus.start = 1'b0;
    if (n == 256) begin
      // Low SADs while in DONE/IDLE must be ignored.
      bus.sad_valid = 1'b1;
      bus.sad16     = '0;
      bus.sad8      = '0;
    end else begin
      bus.sad_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    res_t got;
    rst = 1'b0;
    bus.sad_valid = 1'b1;
    repeat (3) @(negedge clk);
    got = dut_res();
    checks++;
    if (got !== '0) begin
      failures++; $display("FAIL reset_outputs got=%h exp=0", got);
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      failures++; $display("FAIL reset_flags got busy=%b done=%b exp 0/0", bus.busy, bus.done);
    end
    rst = 1'b1;
    bus.sad16 = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || dut_res() !== '0) begin
      failures++; $display("FAIL idle_ignores_valid got busy=%b res=%h", bus.busy, dut_res());
    end
    bus.sad_valid = 1'b0;
  endtask

  task automatic test_single_min();
    res_t exp, got;
    bit   ds;
    int   early, base;
    for (int i = 0; i < 256; i++) begin
      c16[i] = 16'd1000;
      for (int k = 0; k < 4; k++) c8[k][i] = 16'($urandom_range(1, 60000));
    end
    c16[107] = 16'd300;
    exp_q.push_back(model());
    base = done_cnt;
    drive_search(1'b0, 1'b0, 256, ds, early);
    got = dut_res();
    checks++;
    if (ds !== 1'b1) begin failures++; $display("FAIL single_done got=%b exp=1", ds); end
    checks++;
    if (exp_q.size() == 0) begin
      failures++; $display("FAIL single_queue got=empty exp=entry");
    end else begin
      exp = exp_q.pop_front();
      if (got !== exp) begin
        failures++; $display("FAIL single_result got=%h exp=%h", got, exp);
      end
    end
    checks++;
    if (got.sad16 !== 16'd300 || got.mx !== mv_t'(3) || got.my !== mv_t'(-2)) begin
      failures++; $display("FAIL single_mv16 got=%0d (%h,%h) exp=300 (03,1e)",
                           got.sad16, got.mx, got.my);
    end
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (done_cnt - base != 1 || early != 0) begin
      failures++; $display("FAIL single_done_count got=%0d early=%0d exp=1", done_cnt - base, early);
    end
    checks++;
    if (dut_res() !== exp) begin
      failures++; $display("FAIL single_hold got=%h exp=%h", dut_res(), exp);
    end
    bus.sad_valid = 1'b0;
  endtask

  task automatic test_tie();
    res_t exp, got;
    bit   ds;
    int   early;
    for (int i = 0; i < 256; i++) begin
      c16[i] = 16'd900;
      for (int k = 0; k < 4; k++) c8[k][i] = 16'd900;
    end
    c8[2][0]   = 16'd50;
    c8[2][255] = 16'd50;
    exp_q.push_back(model());
    drive_search(1'b0, 1'b0, 256, ds, early);
    got = dut_res();
    checks++;
    if (exp_q.size() == 0) begin
      failures++; $display("FAIL tie_queue got=empty exp=entry");
    end else begin
      exp = exp_q.pop_front();
      if (got !== exp || ds !== 1'b1) begin
        failures++; $display("FAIL tie_result got=%h done=%b exp=%h", got, ds, exp);
      end
    end
    checks++;
    if (got.sad8[2] !== 16'd50 || got.m8x[2] !== mv_t'(-8) || got.m8y[2] !== mv_t'(-8)) begin
      failures++; $display("FAIL tie_first_wins got=%0d (%h,%h) exp=50 (18,18)",
                           got.sad8[2], got.m8x[2], got.m8y[2]);
    end
    @(negedge clk);
    bus.sad_valid = 1'b0;
  endtask

  task automatic test_last();
    res_t exp, got;
    bit   ds;
    int   early, base;
    for (int i = 0; i < 256; i++) begin
      c16[i] = 16'd100;
      for (int k = 0; k < 4; k++) c8[k][i] = 16'($urandom_range(0, 300));
    end
    c16[255] = 16'd10;
    exp_q.push_back(model());
    base = done_cnt;
    drive_search(1'b0, 1'b0, 256, ds, early);
    got = dut_res();
    checks++;
    if (ds !== 1'b1 || early != 0) begin
      failures++; $display("FAIL last_done_timing got done=%b early=%0d exp 1/0", ds, early);
    end
    checks++;
    if (exp_q.size() == 0) begin
      failures++; $display("FAIL last_queue got=empty exp=entry");
    end else begin
      exp = exp_q.pop_front();
      if (got !== exp) begin
        failures++; $display("FAIL last_result got=%h exp=%h", got, exp);
      end
    end
    checks++;
    if (got.sad16 !== 16'd10 || got.mx !== mv_t'(7) || got.my !== mv_t'(7)) begin
      failures++; $display("FAIL last_mv16 got=%0d (%h,%h) exp=10 (07,07)",
                           got.sad16, got.mx, got.my);
    end
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (done_cnt - base != 1) begin
      failures++; $display("FAIL last_done_count got=%0d exp=1", done_cnt - base);
    end
    bus.sad_valid = 1'b0;
  endtask

  task automatic test_gaps_start();
    res_t exp, got;
    bit   ds;
    int   early, base;
    for (int i = 0; i < 256; i++) begin
      c16[i] = 16'($urandom_range(0, 200));
      for (int k = 0; k < 4; k++) c8[k][i] = 16'($urandom_range(0, 200));
    end
    exp_q.push_back(model());
    base = done_cnt;
    drive_search(1'b1, 1'b1, 256, ds, early);
    got = dut_res();
    checks++;
    if (ds !== 1'b1 || early != 0) begin
      failures++; $display("FAIL gaps_done got done=%b early=%0d exp 1/0", ds, early);
    end
    checks++;
    if (exp_q.size() == 0) begin
      failures++; $display("FAIL gaps_queue got=empty exp=entry");
    end else begin
      exp = exp_q.pop_front();
      if (got !== exp) begin
        failures++; $display("FAIL gaps_result got=%h exp=%h", got, exp);
      end
    end
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (done_cnt - base != 1 || bus.busy !== 1'b0) begin
      failures++; $display("FAIL gaps_done_count got=%0d busy=%b exp=1/0", done_cnt - base, bus.busy);
    end
    bus.sad_valid = 1'b0;
  endtask

  task automatic test_reset_abort();
    res_t exp, got;
    bit   ds;
    int   early, base;
    for (int i = 0; i < 256; i++) begin
      c16[i] = 16'd5;
      for (int k = 0; k < 4; k++) c8[k][i] = 16'd3;
    end
    base = done_cnt;
    drive_search(1'b0, 1'b0, 100, ds, early);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    checks++;
    if (dut_res() !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      failures++; $display("FAIL abort_reset got res=%h busy=%b done=%b exp 0",
                           dut_res(), bus.busy, bus.done);
    end
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (done_cnt != base || early != 0) begin
      failures++; $display("FAIL abort_no_done got=%0d early=%0d exp=%0d", done_cnt, early, base);
    end
    @(negedge clk);
    for (int i = 0; i < 256; i++) begin
      c16[i] = 16'd1000;
      for (int k = 0; k < 4; k++) c8[k][i] = 16'($urandom_range(100, 900));
    end
    c16[136] = 16'd20;
    exp_q.push_back(model());
    drive_search(1'b0, 1'b0, 256, ds, early);
    got = dut_res();
    checks++;
    if (exp_q.size() == 0) begin
      failures++; $display("FAIL abort_queue got=empty exp=entry");
    end else begin
      exp = exp_q.pop_front();
      if (got !== exp || ds !== 1'b1) begin
        failures++; $display("FAIL abort_result got=%h done=%b exp=%h", got, ds, exp);
      end
    end
    checks++;
    if (got.sad16 !== 16'd20 || got.mx !== mv_t'(0) || got.my !== mv_t'(0)) begin
      failures++; $display("FAIL abort_mv16 got=%0d (%h,%h) exp=20 (00,00)",
                           got.sad16, got.mx, got.my);
    end
    @(negedge clk);
    bus.sad_valid = 1'b0;
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    done_cnt      = 0;
    rst           = 1'b0;
    bus.start     = 1'b0;
    bus.sad_valid = 1'b0;
    bus.sad16     = '0;
    bus.sad8      = '0;
    @(negedge clk);
    test_reset();
    test_single_min();
    test_tie();
    test_last();
    test_gaps_start();
    test_reset_abort();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
